// File: rtl/sram_burst_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_burst_arbiter_if
// Bundles the three requester channels and the SRAM macro pins that surround
// sram_burst_arbiter.
//   req[2:0]      burst request (0 core read, 1 psum writeback, 2 host)
//   we[2:0]       per-requester direction, 1 = write
//   addrN / lenN  burst base address and beat count minus one, held with req
//   wdataN        write data for the owner's current beat
//   gnt / beat    one-hot first-beat pulse / every-beat strobe
//   rvalid/rdata  one-hot read-return strobe and shared read data
//   busy          arbiter is running a burst
//   sram_*        single-port SRAM pins (cen/wen active-low)
// modport slave  : the arbiter's view
// modport master : requesters plus the SRAM macro
// ---------------------------------------------------------------------------
interface sram_burst_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic [2:0]        req;
   logic [2:0]        we;
   logic [ADDR_W-1:0] addr0, addr1, addr2;
   logic [7:0]        len0, len1, len2;
   logic [DATA_W-1:0] wdata0, wdata1, wdata2;
   logic [2:0]        gnt;
   logic [2:0]        beat;
   logic [2:0]        rvalid;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              sram_cen;
   logic              sram_wen;
   logic [ADDR_W-1:0] sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_q;

   modport slave (
      input  req, we, addr0, addr1, addr2, len0, len1, len2,
             wdata0, wdata1, wdata2, sram_q,
      output gnt, beat, rvalid, rdata, busy,
             sram_cen, sram_wen, sram_a, sram_d
   );

   modport master (
      output req, we, addr0, addr1, addr2, len0, len1, len2,
             wdata0, wdata1, wdata2, sram_q,
      input  gnt, beat, rvalid, rdata, busy,
             sram_cen, sram_wen, sram_a, sram_d
   );
endinterface

// File: rtl/sram_burst_arbiter.sv
// ---------------------------------------------------------------------------
// sram_burst_arbiter
// Shares one single-port, 1-cycle-read SRAM between the core L0-fill reader,
// the psum writeback path and the host loader. Whole bursts of consecutive
// addresses are granted round-robin, one SRAM access per cycle, and read
// data is steered back to the requester that issued it.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    sram_burst_arbiter_if.slave (requester channels + SRAM pins)
// ---------------------------------------------------------------------------
module sram_burst_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   sram_burst_arbiter_if.slave  bus
);

   typedef enum logic {IDLE, BURST} state_e;

   state_e            state_q;
   logic [1:0]        owner_q;
   logic [1:0]        last_owner_q;
   logic [ADDR_W-1:0] base_q;
   logic [7:0]        cnt_q;
   logic [7:0]        blen_q;
   logic              bwe_q;
   logic              rd_pend_q;
   logic [1:0]        rd_owner_q;

   // Round-robin successor over the three requesters (0 -> 1 -> 2 -> 0).
   function automatic logic [1:0] rr_next(input logic [1:0] o);
      return (o == 2'd2) ? 2'd0 : o + 2'd1;
   endfunction

   logic [1:0]        cand0_d, cand1_d;
   logic              pick_valid_d;
   logic [1:0]        pick_d;
   logic [ADDR_W-1:0] sel_addr_d;
   logic [7:0]        sel_len_d;
   logic              sel_we_d;

   // Search order starts just after the last owner, so the last owner is
   // considered last and nobody waits behind more than two other bursts.
   assign cand0_d = rr_next(last_owner_q);
   assign cand1_d = rr_next(cand0_d);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      pick_valid_d = 1'b1;
      pick_d       = last_owner_q;
      if (bus.req[cand0_d])           pick_d = cand0_d;
      else if (bus.req[cand1_d])      pick_d = cand1_d;
      else if (bus.req[last_owner_q]) pick_d = last_owner_q;
      else                            pick_valid_d = 1'b0;
   end

   always_comb begin
      sel_addr_d = bus.addr0;
      sel_len_d  = bus.len0;
      case (pick_d)
         2'd1: begin
            sel_addr_d = bus.addr1;
            sel_len_d  = bus.len1;
         end
         2'd2: begin
            sel_addr_d = bus.addr2;
            sel_len_d  = bus.len2;
         end
         default: ;
      endcase
      sel_we_d = bus.we[pick_d];
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 2'd0;
         last_owner_q <= 2'd2;
         base_q       <= '0;
         cnt_q        <= '0;
         blen_q       <= '0;
         bwe_q        <= 1'b0;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 2'd0;
      end else begin
         // A read beat returns data one cycle later; remember who asked.
         rd_pend_q  <= (state_q == BURST) && !bwe_q;
         rd_owner_q <= owner_q;
         case (state_q)
            IDLE: begin
               if (pick_valid_d) begin
                  owner_q <= pick_d;
                  base_q  <= sel_addr_d;
                  blen_q  <= sel_len_d;
                  bwe_q   <= sel_we_d;
                  cnt_q   <= '0;
                  state_q <= BURST;
               end
            end
            BURST: begin
               if (cnt_q == blen_q) begin
                  state_q      <= IDLE;
                  last_owner_q <= owner_q;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Owner's write data for the current beat.
   logic [DATA_W-1:0] owner_wdata;
   always_comb begin
      case (owner_q)
         2'd1:    owner_wdata = bus.wdata1;
         2'd2:    owner_wdata = bus.wdata2;
         default: owner_wdata = bus.wdata0;
      endcase
   end

   // Outputs are decoded from the burst registers; the address adder wraps
   // silently at 2^ADDR_W.
   always_comb begin
      bus.gnt      = 3'b000;
      bus.beat     = 3'b000;
      bus.busy     = 1'b0;
      bus.sram_cen = 1'b1;
      bus.sram_wen = 1'b1;
      bus.sram_a   = '0;
      bus.sram_d   = '0;
      if (state_q == BURST) begin
         bus.beat     = 3'b001 << owner_q;
         bus.gnt      = (cnt_q == 8'd0) ? (3'b001 << owner_q) : 3'b000;
         bus.busy     = 1'b1;
         bus.sram_cen = 1'b0;
         bus.sram_wen = ~bwe_q;
         bus.sram_a   = base_q + ADDR_W'(cnt_q);
         bus.sram_d   = bwe_q ? owner_wdata : '0;
      end
   end

   assign bus.rvalid = rd_pend_q ? (3'b001 << rd_owner_q) : 3'b000;
   assign bus.rdata  = bus.sram_q;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_burst_arbiter
// Directed bench for sram_burst_arbiter with a behavioural 1-cycle SRAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_sram_burst_arbiter;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sram_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Background contents of untouched SRAM words.
   function automatic logic [31:0] pat(input int a);
      return 32'hC0DE_0000 | (a & 32'h0000_07FF);
   endfunction

   // SRAM macro model: write or read at the edge closing the access cycle.
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic mem_ready = 1'b0;
   always @(posedge clk) begin
      if (reset && !mem_ready) begin
         for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= pat(i);
         mem_ready <= 1'b1;
      end else if (!bus.sram_cen) begin
         if (!bus.sram_wen) mem[bus.sram_a] <= bus.sram_d;
         else               bus.sram_q      <= mem[bus.sram_a];
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   int rr_exp   [11] = '{1, 0, 2, 0, 4, 0, 1, 0, 2, 0, 4};
   int wrap_exp [4]  = '{'h7FE, 'h7FF, 'h000, 'h001};
   int n_beat, n_rv, n_gnt;

   initial begin
      bus.req = 0;    bus.we = 0;
      bus.addr0 = 0;  bus.addr1 = 0;  bus.addr2 = 0;
      bus.len0 = 0;   bus.len1 = 0;   bus.len2 = 0;
      bus.wdata0 = 0; bus.wdata1 = 0; bus.wdata2 = 0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      sample();
      check("rst_busy",   32'(bus.busy),     0);
      check("rst_cen",    32'(bus.sram_cen), 1);
      check("rst_wen",    32'(bus.sram_wen), 1);
      check("rst_a",      32'(bus.sram_a),   0);
      check("rst_beat",   32'(bus.beat),     0);
      check("rst_gnt",    32'(bus.gnt),      0);
      check("rst_rvalid", 32'(bus.rvalid),   0);

      // Host write burst: 4 beats at 0x010, data 0xA0..0xA3.
      step();
      bus.req = 4; bus.we = 4; bus.addr2 = 'h010; bus.len2 = 3; bus.wdata2 = 'hA0;
      sample();
      check("hw_pre_busy", 32'(bus.busy), 0);
      for (int b = 0; b < 4; b++) begin
         step();
         if (b == 0) bus.req = 0;
         bus.wdata2 = 'hA0 + b;
         sample();
         check("hw_gnt",  32'(bus.gnt),      (b == 0) ? 4 : 0);
         check("hw_beat", 32'(bus.beat),     4);
         check("hw_wen",  32'(bus.sram_wen), 0);
         check("hw_cen",  32'(bus.sram_cen), 0);
         check("hw_a",    32'(bus.sram_a),   'h010 + b);
         check("hw_d",    bus.sram_d,        'hA0 + b);
      end
      step();
      // Core read-back of the same four words, issued during the idle cycle.
      bus.req = 1; bus.we = 0; bus.addr0 = 'h010; bus.len0 = 3;
      sample();
      check("hw_idle_busy", 32'(bus.busy),     0);
      check("hw_idle_beat", 32'(bus.beat),     0);
      check("hw_idle_cen",  32'(bus.sram_cen), 1);
      for (int b = 0; b < 4; b++) begin
         step();
         if (b == 0) bus.req = 0;
         sample();
         check("cr_gnt",    32'(bus.gnt),      (b == 0) ? 1 : 0);
         check("cr_beat",   32'(bus.beat),     1);
         check("cr_wen",    32'(bus.sram_wen), 1);
         check("cr_a",      32'(bus.sram_a),   'h010 + b);
         check("cr_d",      bus.sram_d,        0);
         check("cr_rvalid", 32'(bus.rvalid),   (b == 0) ? 0 : 1);
         if (b > 0) check("cr_rdata", bus.rdata, 'hA0 + b - 1);
      end
      step();
      sample();
      check("cr_last_rvalid", 32'(bus.rvalid), 1);
      check("cr_last_rdata",  bus.rdata,       'hA3);
      check("cr_last_busy",   32'(bus.busy),   0);

      // Round-robin after reset: all three request single-beat reads.
      step();
      reset = 1'b1;
      sample();
      step();
      reset = 1'b0;
      bus.req = 7; bus.we = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.addr2 = 0;
      bus.len0 = 0;  bus.len1 = 0;  bus.len2 = 0;
      sample();
      check("rr_pre_busy",   32'(bus.busy),   0);
      check("rr_pre_rvalid", 32'(bus.rvalid), 0);
      for (int i = 0; i < 11; i++) begin
         step();
         if (i == 10) bus.req = 0;
         sample();
         check("rr_gnt",  32'(bus.gnt),  rr_exp[i]);
         check("rr_busy", 32'(bus.busy), (i % 2 == 0) ? 1 : 0);
      end

      // Address wrap on a psum write burst.
      step();
      bus.req = 2; bus.we = 2; bus.addr1 = 'h7FE; bus.len1 = 3; bus.wdata1 = 'hB0;
      sample();
      check("wr_pre_busy", 32'(bus.busy), 0);
      for (int b = 0; b < 4; b++) begin
         step();
         if (b == 0) bus.req = 0;
         bus.wdata1 = 'hB0 + b;
         sample();
         check("wr_a",    32'(bus.sram_a),   wrap_exp[b]);
         check("wr_wen",  32'(bus.sram_wen), 0);
         check("wr_beat", 32'(bus.beat),     2);
         check("wr_d",    bus.sram_d,        'hB0 + b);
      end

      // Reset in the middle of a 16-beat host read.
      step();
      bus.req = 4; bus.we = 0; bus.addr2 = 'h020; bus.len2 = 15;
      sample();
      check("rm_pre_busy", 32'(bus.busy), 0);
      for (int b = 0; b < 6; b++) begin
         step();
         if (b == 0) bus.req = 0;
         if (b == 5) reset = 1'b1;
         sample();
         check("rm_beat", 32'(bus.beat),   4);
         check("rm_a",    32'(bus.sram_a), 'h020 + b);
      end
      step();
      reset = 1'b0;
      bus.req = 6; bus.we = 0;
      bus.addr1 = 'h030; bus.len1 = 0; bus.addr2 = 'h040; bus.len2 = 0;
      sample();
      check("rm_cen",    32'(bus.sram_cen), 1);
      check("rm_beat0",  32'(bus.beat),     0);
      check("rm_rvalid", 32'(bus.rvalid),   0);
      check("rm_busy",   32'(bus.busy),     0);
      step();
      sample();
      check("rm_gnt1", 32'(bus.gnt),    2);
      check("rm_a1",   32'(bus.sram_a), 'h030);
      step();
      sample();
      check("rm_rv1",    32'(bus.rvalid), 2);
      check("rm_rdata1", bus.rdata,       pat('h030));
      check("rm_idle1",  32'(bus.gnt),    0);
      step();
      bus.req = 0;
      sample();
      check("rm_gnt2", 32'(bus.gnt),    4);
      check("rm_a2",   32'(bus.sram_a), 'h040);
      step();
      sample();
      check("rm_rv2",    32'(bus.rvalid), 4);
      check("rm_rdata2", bus.rdata,       pat('h040));

      // Maximum-length core read with req dropped right after the grant.
      step();
      bus.req = 1; bus.we = 0; bus.addr0 = 'h100; bus.len0 = 255;
      sample();
      check("ml_pre_busy", 32'(bus.busy), 0);
      n_beat = 0; n_rv = 0; n_gnt = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 0) bus.req = 0;
         sample();
         if (bus.beat[0])   n_beat++;
         if (bus.rvalid[0]) n_rv++;
         if (bus.gnt != 0)  n_gnt++;
         if (i == 1)   check("ml_rdata_first", bus.rdata, pat('h100));
         if (i == 255) check("ml_busy_last",   32'(bus.busy), 1);
         if (i == 256) begin
            check("ml_rdata_last", bus.rdata,      pat('h1FF));
            check("ml_busy_end",   32'(bus.busy), 0);
         end
      end
      check("ml_beats",  n_beat, 256);
      check("ml_rvalid", n_rv,   256);
      check("ml_grants", n_gnt,  1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_burst_arbiter.md
# sram_burst_arbiter

Shares one single-port, 1-cycle-read SRAM (activation/weight buffer) between three requesters: the core L0-fill reader, the psum writeback path, and the host loader. Each requester asks for a whole burst of consecutive addresses. The arbiter grants bursts in round-robin order, sequences one SRAM access per cycle, and routes read data back to the owner. It sits between the array controller / host interface and the SRAM macro, below the top-level sequencer.

## Interface
- ADDR_W, 11, SRAM address width
- DATA_W, 32, SRAM word width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  3  burst request per requester (bit 0 core read, bit 1 psum writeback, bit 2 host)
- we  in  3  per-requester direction: 1 write, 0 read; held with req
- addr0/addr1/addr2  in  ADDR_W each  burst base address; held with req
- len0/len1/len2  in  8 each  burst beats minus 1 (0 → 1 beat, 255 → 256 beats)
- wdata0/wdata1/wdata2  in  DATA_W each  write data for the current beat
- gnt  out  3  one-hot, one-cycle pulse on the first beat of a granted burst
- beat  out  3  one-hot, high on every beat cycle of the owner's burst; for writes, wdata of the owner is consumed this cycle
- rvalid  out  3  one-hot, read data valid for the owner
- rdata  out  DATA_W  read data, combinational passthrough of sram_q
- busy  out  1  high while in BURST
- sram_cen  out  1  chip enable, active-low
- sram_wen  out  1  write enable, active-low
- sram_a  out  ADDR_W  SRAM address
- sram_d  out  DATA_W  SRAM write data
- sram_q  in  DATA_W  SRAM read data, valid the cycle after the read address edge

## Operation
- States: IDLE and BURST.
- Registers:
  - state
  - owner (2 bits)
  - last_owner (2 bits, reset value 2)
  - base (ADDR_W), cnt (8), blen (8), bwe (1)
  - rd_pend (1), rd_owner (2)
- IDLE, at a clock edge with req != 0:
  - Pick the first set req bit, searching (last_owner+1) mod 3, then +2, then +3.
  - Latch owner, base=addrN, blen=lenN, bwe=weN; set cnt=0 and state=BURST.
- BURST (outputs decoded from registers):
  - sram_cen=0; sram_wen=~bwe; sram_a=(base+cnt) mod 2^ADDR_W, so wrap-around is silent.
  - sram_d=wdata[owner] when bwe, else 0.
  - beat[owner]=1; gnt[owner]=1 only when cnt==0; busy=1.
- Each BURST edge:
  - If cnt==blen: state=IDLE, last_owner=owner.
  - Otherwise cnt+1.
- Read return:
  - At each edge, rd_pend=(BURST & ~bwe) and rd_owner=owner.
  - rvalid[rd_owner]=rd_pend; rdata=sram_q.
- Requests:
  - req/we/addr/len are sampled only in IDLE.
  - A requester holds them stable until gnt.
  - Dropping req mid-burst has no effect; the burst always completes.
  - req still high when the arbiter returns to IDLE counts as a new request.
- Outside BURST: sram_cen=1, sram_wen=1, sram_a=0, sram_d=0, gnt=0, beat=0, busy=0.
- Reset:
  - state=IDLE, last_owner=2, cnt=0, rd_pend=0.
  - All outputs take their idle values the next cycle. rvalid=0 even if a read was in flight.
  - Reset during a burst abandons it with no further SRAM access.

## Timing
- Request latency: req sampled at edge k in IDLE → first beat and gnt during cycle k..k+1.
- A burst with len=L occupies exactly L+1 consecutive beat cycles with no bubbles.
- Turnaround: exactly one IDLE cycle between back-to-back bursts, including when the same requester is re-granted.
- Read latency: the rvalid/rdata of a beat appear in the cycle after that beat.
  - The last read's rvalid overlaps the following IDLE cycle.
  - Data order equals address order.
- Write: sram_d/sram_a/sram_wen are valid throughout the beat cycle and captured by the SRAM at its closing edge.
- Simultaneous requests: exactly one grant per arbitration; no requester waits more than two other bursts.

## Test plan
- Host write burst: req=3'b100, we2=1, addr2=0x010, len2=3, wdata = 0xA0..0xA3 per beat.
  - gnt[2] is one cycle; beat[2] is 4 cycles.
  - sram_a = 0x010..0x013, sram_wen=0.
  - Then IDLE for one cycle.
- Core read-back: req[0], addr0=0x010, len0=3.
  - rvalid[0] is 4 cycles, starting one cycle after the first beat.
  - rdata = 0xA0, 0xA1, 0xA2, 0xA3.
- Round-robin after reset: req=3'b111 held, each len=0.
  - Grant order 0, 1, 2, 0, 1, 2, each separated by one idle cycle.
- Address wrap: addr1=0x7FE, len1=3, write.
  - sram_a = 0x7FE, 0x7FF, 0x000, 0x001.
- Reset mid-burst: host read len=15, reset asserted at beat 5 for one cycle.
  - Next cycle: sram_cen=1, beat=0, rvalid=0, busy=0.
  - A subsequent req[1] is granted first (last_owner=2).
- Max length and early req drop: len0=255, req[0] dropped after gnt.
  - Exactly 256 beats and 256 rvalid pulses; no re-grant.
